// File: rtl/cursor_tracker.sv
// cursor_tracker: turns per-axis encoder step pulses into a clamped pen
// cursor on the drawing grid, emits 1-pixel ink writes while the pen is down
// and performs a full-grid erase sweep on request.
//
// Write port handshake: a transfer happens on a rising clk edge where
// wr_valid and wr_ready are both high. While wr_valid is high and wr_ready is
// low, wr_x, wr_y and wr_data hold their values. wr_valid drops in the cycle
// after the transfer, except when a clear sweep follows directly.
module cursor_tracker #(
    parameter int GRID_W  = 160,
    parameter int GRID_H  = 120,
    parameter int XW      = 8,
    parameter int YW      = 7,
    parameter int START_X = 80,
    parameter int START_Y = 60
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          x_inc,
    input  logic          x_dec,
    input  logic          y_inc,
    input  logic          y_dec,
    input  logic          pen_down,
    input  logic          clear_req,
    input  logic          wr_ready,
    output logic          wr_valid,
    output logic [XW-1:0] wr_x,
    output logic [YW-1:0] wr_y,
    output logic          wr_data,
    output logic [XW-1:0] cursor_x,
    output logic [YW-1:0] cursor_y,
    output logic          busy,
    output logic          move_dropped
);

    localparam logic [XW-1:0] X_MAX   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_MAX   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] X_START = XW'(START_X);
    localparam logic [YW-1:0] Y_START = YW'(START_Y);
    localparam logic [XW-1:0] X_ONE   = XW'(1);
    localparam logic [YW-1:0] Y_ONE   = YW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic          wr_valid_q, wr_valid_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic          wr_data_q, wr_data_d;
    logic          pend_q, pend_d;
    logic          pen_prev_q, pen_prev_d;
    logic          dropped_q, dropped_d;

    logic          x_up, x_dn, y_up, y_dn;
    logic          moved, any_pulse, xfer;
    logic [XW-1:0] step_x;
    logic [YW-1:0] step_y;

    // A pulse only counts as a move when the opposite pulse is absent and
    // the cursor is not already sitting on that limit.
    assign x_up      = x_inc & ~x_dec & (cur_x_q != X_MAX);
    assign x_dn      = x_dec & ~x_inc & (cur_x_q != '0);
    assign y_up      = y_inc & ~y_dec & (cur_y_q != Y_MAX);
    assign y_dn      = y_dec & ~y_inc & (cur_y_q != '0);
    assign moved     = x_up | x_dn | y_up | y_dn;
    assign any_pulse = x_inc | x_dec | y_inc | y_dec;
    assign xfer      = wr_valid_q & wr_ready;

    // Candidate cursor position for this cycle's step pulses.
    always_comb begin
        step_x = cur_x_q;
        step_y = cur_y_q;
        if (x_up)      step_x = cur_x_q + X_ONE;
        else if (x_dn) step_x = cur_x_q - X_ONE;
        if (y_up)      step_y = cur_y_q + Y_ONE;
        else if (y_dn) step_y = cur_y_q - Y_ONE;
    end

    // Next-state and next-output logic for the IDLE/WRITE/CLEAR controller.
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        wr_valid_d = wr_valid_q;
        wr_x_d     = wr_x_q;
        wr_y_d     = wr_y_q;
        wr_data_d  = wr_data_q;
        pend_d     = pend_q;
        pen_prev_d = pen_prev_q;
        dropped_d  = dropped_q;
        case (state_q)
            IDLE: begin
                pen_prev_d = pen_down;
                if (clear_req) begin
                    state_d    = CLEAR;
                    wr_valid_d = 1'b1;
                    wr_x_d     = '0;
                    wr_y_d     = '0;
                    wr_data_d  = 1'b0;
                end else begin
                    cur_x_d = step_x;
                    cur_y_d = step_y;
                    if (pen_down && (moved || !pen_prev_q)) begin
                        state_d    = WRITE;
                        wr_valid_d = 1'b1;
                        wr_x_d     = step_x;
                        wr_y_d     = step_y;
                        wr_data_d  = 1'b1;
                    end
                end
            end
            WRITE: begin
                if (any_pulse) dropped_d = 1'b1;
                if (clear_req) pend_d = 1'b1;
                if (xfer) begin
                    if (pend_q || clear_req) begin
                        // Go straight into the sweep; wr_valid stays high.
                        state_d   = CLEAR;
                        pend_d    = 1'b0;
                        wr_x_d    = '0;
                        wr_y_d    = '0;
                        wr_data_d = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        wr_valid_d = 1'b0;
                    end
                end
            end
            CLEAR: begin
                if (xfer) begin
                    if (wr_x_q == X_MAX) begin
                        if (wr_y_q == Y_MAX) begin
                            state_d    = IDLE;
                            wr_valid_d = 1'b0;
                            cur_x_d    = X_START;
                            cur_y_d    = Y_START;
                            dropped_d  = 1'b0;
                        end else begin
                            wr_x_d = '0;
                            wr_y_d = wr_y_q + Y_ONE;
                        end
                    end else begin
                        wr_x_d = wr_x_q + X_ONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_x_q    <= X_START;
            cur_y_q    <= Y_START;
            wr_valid_q <= 1'b0;
            wr_x_q     <= '0;
            wr_y_q     <= '0;
            wr_data_q  <= 1'b0;
            pend_q     <= 1'b0;
            pen_prev_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            wr_valid_q <= wr_valid_d;
            wr_x_q     <= wr_x_d;
            wr_y_q     <= wr_y_d;
            wr_data_q  <= wr_data_d;
            pend_q     <= pend_d;
            pen_prev_q <= pen_prev_d;
            dropped_q  <= dropped_d;
        end
    end

    assign wr_valid     = wr_valid_q;
    assign wr_x         = wr_x_q;
    assign wr_y         = wr_y_q;
    assign wr_data      = wr_data_q;
    assign cursor_x     = cur_x_q;
    assign cursor_y     = cur_y_q;
    assign busy         = (state_q == CLEAR);
    assign move_dropped = dropped_q;

endmodule

// File: tb/tb_cursor_tracker.sv
// Bench for cursor_tracker: directed steps plus a randomized section, with a
// pixel-level reference model (clamped integer cursor, expected write queue).
module tb_cursor_tracker;

    localparam int GRID_W  = 160;
    localparam int GRID_H  = 120;
    localparam int XW      = 8;
    localparam int YW      = 7;
    localparam int START_X = 80;
    localparam int START_Y = 60;
    localparam int EW      = XW + YW + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          x_inc = 1'b0, x_dec = 1'b0, y_inc = 1'b0, y_dec = 1'b0;
    logic          pen_down = 1'b0, clear_req = 1'b0, wr_ready = 1'b0;
    logic          wr_valid, wr_data, busy, move_dropped;
    logic [XW-1:0] wr_x, cursor_x;
    logic [YW-1:0] wr_y, cursor_y;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [EW-1:0] exp_q[$];
    int            mx, my;
    bit            pen_hist;
    bit            drop_exp;

    cursor_tracker #(
        .GRID_W(GRID_W), .GRID_H(GRID_H), .XW(XW), .YW(YW),
        .START_X(START_X), .START_Y(START_Y)
    ) dut (
        .clk(clk), .reset(reset),
        .x_inc(x_inc), .x_dec(x_dec), .y_inc(y_inc), .y_dec(y_dec),
        .pen_down(pen_down), .clear_req(clear_req), .wr_ready(wr_ready),
        .wr_valid(wr_valid), .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data),
        .cursor_x(cursor_x), .cursor_y(cursor_y),
        .busy(busy), .move_dropped(move_dropped)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // scoreboard: every valid cycle must match the head of the expected queue
    always @(negedge clk) begin
        if (!reset && wr_valid) begin
            check("valid_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("wr_fields", 32'({wr_x, wr_y, wr_data}), 32'(exp_q[0]));
                if (wr_ready) void'(exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_clear();
        for (int y = 0; y < GRID_H; y++)
            for (int x = 0; x < GRID_W; x++)
                exp_q.push_back({XW'(x), YW'(y), 1'b0});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        x_inc = 0; x_dec = 0; y_inc = 0; y_dec = 0;
        pen_down = 0; clear_req = 0; wr_ready = 0;
        exp_q.delete();
        mx = START_X; my = START_Y; pen_hist = 0; drop_exp = 0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // one cycle spent in IDLE; model applies clamped steps and the ink rule
    task automatic idle_cycle(input bit xi, input bit xd, input bit yi, input bit yd, input bit clr);
        int nx, ny;
        x_inc = xi; x_dec = xd; y_inc = yi; y_dec = yd; clear_req = clr;
        tick();
        x_inc = 0; x_dec = 0; y_inc = 0; y_dec = 0; clear_req = 0;
        nx = mx;
        ny = my;
        if (clr) begin
            push_clear();
        end else begin
            if (xi && !xd)      nx = (mx < GRID_W - 1) ? mx + 1 : mx;
            else if (xd && !xi) nx = (mx > 0) ? mx - 1 : mx;
            if (yi && !yd)      ny = (my < GRID_H - 1) ? my + 1 : my;
            else if (yd && !yi) ny = (my > 0) ? my - 1 : my;
            if (pen_down && (nx != mx || ny != my || !pen_hist))
                exp_q.push_back({XW'(nx), YW'(ny), 1'b1});
            mx = nx;
            my = ny;
        end
        pen_hist = pen_down;
    endtask

    // one cycle while a write is outstanding: moves are discarded
    task automatic write_cycle(input bit xi, input bit xd, input bit yi, input bit yd, input bit clr);
        x_inc = xi; x_dec = xd; y_inc = yi; y_dec = yd; clear_req = clr;
        tick();
        x_inc = 0; x_dec = 0; y_inc = 0; y_dec = 0; clear_req = 0;
        if (xi | xd | yi | yd) drop_exp = 1;
        if (clr) push_clear();
    endtask

    // mode 0: ready always high, 1: random, 2: toggling
    task automatic wait_drain(input int mode, input bit expect_idle, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = n[0];
            endcase
            tick();
            n++;
        end
        wr_ready = 1'b0;
        check("drain_done", 32'(exp_q.size()), 32'd0);
        if (expect_idle) check("valid_released", 32'(wr_valid), 32'd0);
        exp_q.delete();
    endtask

    task automatic check_cursor(input string tag);
        check({tag, "_x"}, 32'(cursor_x), 32'(mx));
        check({tag, "_y"}, 32'(cursor_y), 32'(my));
    endtask

    initial begin
        // 1: reset values, pen-up moves
        do_reset();
        check_cursor("reset");
        check("reset_valid", 32'(wr_valid), 32'd0);
        check("reset_wr_x", 32'(wr_x), 32'd0);
        check("reset_wr_y", 32'(wr_y), 32'd0);
        check("reset_data", 32'(wr_data), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_drop", 32'(move_dropped), 32'd0);
        for (int i = 0; i < 3; i++) idle_cycle(1, 0, 0, 0, 0);
        check_cursor("pen_up");
        check("pen_up_x83", 32'(cursor_x), 32'd83);

        // 2: pen rising inks current pixel, then a y_dec step
        do_reset();
        pen_down = 1;
        idle_cycle(0, 0, 0, 0, 0);
        check("pen_rise_queued", 32'(exp_q.size()), 32'd1);
        wait_drain(0, 1, 20);
        idle_cycle(0, 0, 0, 1, 0);
        check_cursor("ydec");
        check("ydec_y59", 32'(cursor_y), 32'd59);
        wait_drain(0, 1, 20);

        // 3: clamp at (159,0)
        pen_down = 0;
        for (int i = 0; i < 80; i++) idle_cycle(1, 0, 0, 1, 0);
        check_cursor("corner");
        pen_down = 1;
        idle_cycle(0, 0, 0, 0, 0);
        wait_drain(0, 1, 20);
        idle_cycle(1, 0, 0, 1, 0);
        check_cursor("clamp");
        check("clamp_no_write", 32'(wr_valid), 32'd0);

        // 4: stalled write with a dropped move
        idle_cycle(0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) write_cycle(i == 1, 0, 0, 0, 0);
        check("stall_drop", 32'(move_dropped), 32'(drop_exp));
        check_cursor("stall");
        wait_drain(0, 1, 20);

        // 5: opposing pulses, then diagonal steps
        idle_cycle(1, 1, 0, 0, 0);
        check_cursor("opposed");
        check("opposed_no_write", 32'(wr_valid), 32'd0);
        idle_cycle(0, 1, 1, 0, 0);
        check("diag_one_write", 32'(exp_q.size()), 32'd1);
        wait_drain(1, 1, 200);
        check_cursor("diag");

        // randomized moves, pen and backpressure
        for (int it = 0; it < 80; it++) begin
            pen_down = ($urandom_range(0, 3) != 0);
            idle_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            if (exp_q.size() != 0) begin
                if ($urandom_range(0, 2) == 0)
                    write_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
                wait_drain(1, 1, 200);
            end
            check_cursor("rand");
        end
        check("rand_drop", 32'(move_dropped), 32'(drop_exp));

        // 6: full erase sweep with toggling ready
        pen_down = 0;
        idle_cycle(0, 0, 0, 0, 1);
        check("clear_busy", 32'(busy), 32'd1);
        wait_drain(2, 1, 50000);
        mx = START_X; my = START_Y; drop_exp = 0;
        check("clear_done_busy", 32'(busy), 32'd0);
        check("clear_done_drop", 32'(move_dropped), 32'd0);
        check_cursor("clear_done");

        // clear requested during a write, then reset mid-sweep
        pen_down = 1;
        idle_cycle(0, 0, 0, 0, 0);
        write_cycle(0, 0, 0, 0, 1);
        wr_ready = 1;
        tick();
        check("pend_valid", 32'(wr_valid), 32'd1);
        check("pend_busy", 32'(busy), 32'd1);
        check("pend_origin", 32'({wr_x, wr_y}), 32'd0);
        for (int i = 0; i < 300; i++) tick();
        check("sweep_progress", 32'(exp_q.size()), 32'(GRID_W * GRID_H - 300));
        reset = 1;
        #1;
        exp_q.delete();
        mx = START_X; my = START_Y;
        check("midreset_valid", 32'(wr_valid), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check_cursor("midreset");
        tick();
        reset = 0;
        wr_ready = 0;
        pen_down = 0;
        tick();
        check("after_reset_valid", 32'(wr_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
